// File: rtl/audio_pkg.sv
// Shared widths and FSM state encoding for the clip record/playback path.
package audio_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} clip_state_t;
endpackage

// File: rtl/bit_tick_gen.sv
// Audio bit-rate divider: one-cycle tick every BIT_DIV clocks.
// A synchronous restart forces the count to 0 so the first tick lands BIT_DIV-1 cycles later.
module bit_tick_gen #(
  parameter int BIT_DIV = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(BIT_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/clip_controller.sv
// Record/playback sequencer for two clip BRAMs: serial audio <-> 16-bit words.
// Write strobe 1 cycle after a word completes; playback starts 3 cycles after the play pulse.
module clip_controller #(
  parameter int ADDR_W  = audio_pkg::ADDR_W,
  parameter int DATA_W  = audio_pkg::DATA_W,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int BIT_DIV = 50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clipPlayNum,
  input  logic              clipRecordNum,
  input  logic              play,
  input  logic              record,
  input  logic              audioIn,
  output logic              audioOut,
  output logic              ena0,
  output logic              wea0,
  output logic              ena1,
  output logic              wea1,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta0,
  input  logic [DATA_W-1:0] douta1,
  output logic              busyRec,
  output logic              busyPlay,
  output logic              activeClip
);
  import audio_pkg::*;

  localparam int BW = $clog2(DATA_W);
  localparam int LW = ADDR_W + 1;

  clip_state_t state_q, state_d;

  logic              clip_q, clip_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              aud_q, aud_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [LW-1:0]     len0_q, len0_d;
  logic [LW-1:0]     len1_q, len1_d;

  logic              tick, restart, load_word;
  logic              start_rec, start_play, last_wr, load_first, play_end, word_done;
  logic [DATA_W-1:0] rdata;
  logic [LW-1:0]     cur_len, play_len, wr_count;

  assign rdata      = clip_q ? douta1 : douta0;
  assign cur_len    = clip_q ? len1_q : len0_q;
  assign play_len   = clipPlayNum ? len1_q : len0_q;
  assign wr_count   = {1'b0, addr_q} + LW'(en_q);
  assign start_rec  = (state_q == IDLE) && record;
  assign start_play = (state_q == IDLE) && !record && play && (play_len != '0);
  assign word_done  = tick && (bit_q == BW'(DATA_W - 1));
  assign last_wr    = en_q && we_q && (addr_q == ADDR_W'(DEPTH - 1));
  assign load_first = (state_q == PLAY) && rd_q && first_q;
  assign play_end   = (state_q == PLAY) && !first_q && word_done && last_q;

  // Bit timing in PLAY is anchored on the first word load rather than the start pulse.
  assign restart = start_rec || start_play || load_first;

  bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rec) state_d = RECORD;
               else if (start_play) state_d = PLAY;
      RECORD:  if (record || last_wr) state_d = IDLE;
      PLAY:    if (play || play_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clip_d    = clip_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    rd_d      = 1'b0;
    first_d   = first_q;
    last_d    = last_q;
    aud_d     = aud_q;
    addr_d    = addr_q;
    sr_d      = sr_q;
    hold_d    = hold_q;
    dina_d    = dina_q;
    bit_d     = bit_q;
    len0_d    = len0_q;
    len1_d    = len1_q;
    load_word = 1'b0;
    case (state_q)
      IDLE: begin
        aud_d = 1'b0;
        if (start_rec) begin
          clip_d = clipRecordNum;
          addr_d = '0;
          sr_d   = '0;
          bit_d  = '0;
        end else if (start_play) begin
          clip_d  = clipPlayNum;
          addr_d  = '0;
          en_d    = 1'b1;
          first_d = 1'b1;
          last_d  = 1'b0;
          bit_d   = '0;
        end
      end
      RECORD: begin
        if (en_q) addr_d = addr_q + 1'b1;
        if (record || last_wr) begin
          if (clip_q) len1_d = wr_count;
          else        len0_d = wr_count;
        end else if (tick) begin
          sr_d  = {sr_q[DATA_W-2:0], audioIn};
          bit_d = bit_q + 1'b1;
          if (word_done) begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            dina_d = {sr_q[DATA_W-2:0], audioIn};
            bit_d  = '0;
          end
        end
      end
      PLAY: begin
        if (play) begin
          aud_d = 1'b0;
        end else begin
          rd_d = en_q;
          if (rd_q && first_q) begin
            sr_d      = rdata << 1;
            aud_d     = rdata[DATA_W-1];
            bit_d     = '0;
            first_d   = 1'b0;
            load_word = 1'b1;
          end else if (rd_q) begin
            hold_d = rdata;
          end
          if (!first_q && tick) begin
            if (word_done) begin
              if (last_q) begin
                aud_d = 1'b0;
              end else begin
                sr_d      = hold_q << 1;
                aud_d     = hold_q[DATA_W-1];
                bit_d     = '0;
                load_word = 1'b1;
              end
            end else begin
              aud_d = sr_q[DATA_W-1];
              sr_d  = sr_q << 1;
              bit_d = bit_q + 1'b1;
            end
          end
          // addr_q is the index of the word just loaded; prefetch its successor.
          if (load_word) begin
            if (({1'b0, addr_q} + LW'(1)) < cur_len) begin
              en_d   = 1'b1;
              addr_d = addr_q + 1'b1;
            end else begin
              last_d = 1'b1;
            end
          end
        end
      end
      default: aud_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clip_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      aud_q   <= 1'b0;
      addr_q  <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      dina_q  <= '0;
      bit_q   <= '0;
      len0_q  <= '0;
      len1_q  <= '0;
    end else begin
      clip_q  <= clip_d;
      en_q    <= en_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      first_q <= first_d;
      last_q  <= last_d;
      aud_q   <= aud_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      dina_q  <= dina_d;
      bit_q   <= bit_d;
      len0_q  <= len0_d;
      len1_q  <= len1_d;
    end
  end

  assign ena0       = en_q & ~clip_q;
  assign wea0       = we_q & ~clip_q;
  assign ena1       = en_q & clip_q;
  assign wea1       = we_q & clip_q;
  assign addra      = addr_q;
  assign dina       = dina_q;
  assign audioOut   = aud_q;
  assign busyRec    = (state_q == RECORD);
  assign busyPlay   = (state_q == PLAY);
  assign activeClip = (state_q != IDLE) & clip_q;
endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with DEPTH=4, BIT_DIV=4; BRAM writes go through a scoreboard.
module tb_clip_controller;
  localparam int AW = 17;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clipPlayNum = 1'b0;
  logic          clipRecordNum = 1'b0;
  logic          play = 1'b0;
  logic          record = 1'b0;
  logic          audioIn = 1'b0;
  logic          audioOut;
  logic          ena0, wea0, ena1, wea1;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta0 = '0;
  logic [DW-1:0] douta1 = '0;
  logic          busyRec, busyPlay, activeClip;

  logic [DW-1:0] mem0 [0:3];
  logic [DW-1:0] mem1 [0:3];

  int checks = 0;
  int failures = 0;
  int both_hi = 0;

  typedef struct packed {
    logic          clip;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wr_q[$];

  clip_controller #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .BIT_DIV(4)) dut (
    .clock(clock), .reset(reset), .clipPlayNum(clipPlayNum), .clipRecordNum(clipRecordNum),
    .play(play), .record(record), .audioIn(audioIn), .audioOut(audioOut),
    .ena0(ena0), .wea0(wea0), .ena1(ena1), .wea1(wea1), .addra(addra), .dina(dina),
    .douta0(douta0), .douta1(douta1), .busyRec(busyRec), .busyPlay(busyPlay),
    .activeClip(activeClip)
  );

  always #5 clock = ~clock;

  // Read-first BRAM models, one cycle read latency
  always @(posedge clock) begin
    if (ena0) begin
      if (wea0) mem0[addra[1:0]] <= dina;
      douta0 <= mem0[addra[1:0]];
    end
    if (ena1) begin
      if (wea1) mem1[addra[1:0]] <= dina;
      douta1 <= mem1[addra[1:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every BRAM write strobe is matched against the expected queue
  always @(negedge clock) begin
    wr_t e;
    if (ena0 && ena1) both_hi++;
    if ((ena0 && wea0) || (ena1 && wea1)) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual clip=%0d addr=%0d data=0x%0h required none at %0t",
                 ena1, addra, dina, $time);
      end else begin
        e = wr_q.pop_front();
        chk("wr_clip", 32'(ena1), 32'(e.clip));
        chk("wr_addr", 32'(addra), 32'(e.addr));
        chk("wr_data", 32'(dina), 32'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic clip, input int addr, input logic [DW-1:0] data);
    wr_t e;
    e.clip = clip;
    e.addr = AW'(addr);
    e.data = data;
    wr_q.push_back(e);
  endtask

  // Record pulse, then drive ncyc cycles of audio, each bit held 4 cycles to straddle its tick.
  task automatic rec_task(input logic clip, input logic [DW-1:0] pat, input int ncyc);
    clipRecordNum = clip;
    record = 1'b1;
    step();
    record = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      audioIn = pat[15 - ((j / 4) % 16)];
      step();
    end
    audioIn = 1'b0;
  endtask

  task automatic play_check(input logic clip, input logic [DW-1:0] pat, input int nwords);
    clipPlayNum = clip;
    play = 1'b1;
    step();
    play = 1'b0;
    @(negedge clock);
    chk("rd_strobe", 32'(clip ? ena1 : ena0), 1);
    chk("rd_addr0", 32'(addra), 0);
    @(negedge clock);
    chk("aud_before_first", 32'(audioOut), 0);
    chk("busy_play", 32'(busyPlay), 1);
    for (int k = 0; k < nwords * 64; k++) begin
      @(negedge clock);
      chk("aud_bit", 32'(audioOut), 32'(pat[15 - ((k / 4) % 16)]));
    end
    @(negedge clock);
    chk("aud_end", 32'(audioOut), 0);
    chk("busy_play_end", 32'(busyPlay), 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_audioOut", 32'(audioOut), 0);
    chk("rst_ena0", 32'(ena0), 0);
    chk("rst_ena1", 32'(ena1), 0);
    chk("rst_wea0", 32'(wea0), 0);
    chk("rst_wea1", 32'(wea1), 0);
    chk("rst_addra", 32'(addra), 0);
    chk("rst_dina", 32'(dina), 0);
    chk("rst_busyRec", 32'(busyRec), 0);
    chk("rst_busyPlay", 32'(busyPlay), 0);
    chk("rst_activeClip", 32'(activeClip), 0);
    step();
    reset = 1'b1;
    step();

    // Play of an empty clip does nothing
    clipPlayNum = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("empty_ena0", 32'(ena0), 0);
      chk("empty_busyPlay", 32'(busyPlay), 0);
      chk("empty_audioOut", 32'(audioOut), 0);
      step();
    end

    // Full record of clip 1
    for (int a = 0; a < 4; a++) push_wr(1'b1, a, 16'hA5C3);
    rec_task(1'b1, 16'hA5C3, 256);
    for (int i = 0; i < 10; i++) begin
      if (!busyRec) break;
      step();
    end
    chk("full_rec_idle", 32'(busyRec), 0);
    chk("full_rec_writes", 32'(wr_q.size()), 0);

    // Full playback of clip 1
    play_check(1'b1, 16'hA5C3, 4);

    // record and play together: record wins
    clipRecordNum = 1'b0;
    clipPlayNum = 1'b1;
    record = 1'b1;
    play = 1'b1;
    step();
    record = 1'b0;
    play = 1'b0;
    @(negedge clock);
    chk("simul_busyRec", 32'(busyRec), 1);
    chk("simul_busyPlay", 32'(busyPlay), 0);
    step();
    record = 1'b1;
    step();
    record = 1'b0;
    @(negedge clock);
    chk("simul_stop", 32'(busyRec), 0);
    step();

    // record ignored in PLAY; play pulse stops immediately
    clipPlayNum = 1'b1;
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (20) step();
    record = 1'b1;
    step();
    record = 1'b0;
    @(negedge clock);
    chk("rec_in_play_busyPlay", 32'(busyPlay), 1);
    chk("rec_in_play_busyRec", 32'(busyRec), 0);
    chk("play_activeClip", 32'(activeClip), 1);
    step();
    repeat (44) step();
    play = 1'b1;
    @(negedge clock);
    chk("aud_pre_stop", 32'(audioOut), 1);
    step();
    play = 1'b0;
    @(negedge clock);
    chk("stop_busyPlay", 32'(busyPlay), 0);
    chk("stop_audioOut", 32'(audioOut), 0);
    chk("stop_activeClip", 32'(activeClip), 0);
    repeat (8) begin
      step();
      @(negedge clock);
      chk("stop_no_ena", 32'(ena0 | ena1), 0);
    end
    step();

    // Early stop after 1.5 words on clip 0
    push_wr(1'b0, 0, 16'h1234);
    rec_task(1'b0, 16'h1234, 96);
    chk("addr_after_word0", 32'(addra), 1);
    record = 1'b1;
    step();
    record = 1'b0;
    @(negedge clock);
    chk("early_stop_idle", 32'(busyRec), 0);
    repeat (4) step();
    chk("early_stop_writes", 32'(wr_q.size()), 0);
    play_check(1'b0, 16'h1234, 1);

    // Async reset mid-word during RECORD
    push_wr(1'b0, 0, 16'h8001);
    rec_task(1'b0, 16'h8001, 100);
    chk("addr_pre_reset", 32'(addra), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busyRec", 32'(busyRec), 0);
    chk("arst_addra", 32'(addra), 0);
    chk("arst_dina", 32'(dina), 0);
    chk("arst_ena0", 32'(ena0), 0);
    chk("arst_audioOut", 32'(audioOut), 0);
    step();
    reset = 1'b1;
    step();
    clipPlayNum = 1'b0;
    play = 1'b1;
    step();
    play = 1'b0;
    @(negedge clock);
    chk("arst_len0_busyPlay", 32'(busyPlay), 0);
    chk("arst_len0_ena0", 32'(ena0), 0);
    step();
    clipPlayNum = 1'b1;
    play = 1'b1;
    step();
    play = 1'b0;
    @(negedge clock);
    chk("arst_len1_busyPlay", 32'(busyPlay), 0);
    chk("arst_len1_ena1", 32'(ena1), 0);
    step();

    chk("wr_queue_empty", 32'(wr_q.size()), 0);
    chk("ena_exclusive", 32'(both_hi), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clip_controller.md
# clip_controller

Record/playback sequencer that sits directly upstream of the two clip BRAMs (17-bit address, 16-bit word each). It deserializes the 1-bit audio input into 16-bit words and writes them to the selected clip. It reads words back from a clip and serializes them onto the 1-bit audio output. It also tracks the recorded length of each clip.

## Interface
- `ADDR_W`, default 17: BRAM address width.
- `DATA_W`, default 16: BRAM word width; bits per word.
- `DEPTH`, default 2**17: words per clip, must be ≤ 2**ADDR_W.
- `BIT_DIV`, default 50: clock cycles per audio bit, must be ≥ 4.
- `clock` in 1: single clock; drives the BRAM `clka` pins.
- `reset` in 1: asynchronous, active-low.
- `clipPlayNum` in 1: clip selected for play, sampled at the play start.
- `clipRecordNum` in 1: clip selected for record, sampled at the record start.
- `play` in 1: single-cycle start/stop pulse, debounced upstream.
- `record` in 1: single-cycle start/stop pulse.
- `audioIn` in 1: serial audio bit, already synchronous to `clock`.
- `audioOut` out 1: serial audio bit, registered.
- `ena0`, `wea0` out 1: enable and write enable for clip 0 BRAM.
- `ena1`, `wea1` out 1: enable and write enable for clip 1 BRAM.
- `addra` out ADDR_W: shared address bus to both BRAMs.
- `dina` out DATA_W: shared write data bus to both BRAMs.
- `douta0`, `douta1` in DATA_W: read data, valid 1 cycle after enable.
- `busyRec`, `busyPlay` out 1: state flags.
- `activeClip` out 1: clip currently in use; 0 when idle.

## Operation
- The FSM has three states: IDLE, RECORD, PLAY.
- A bit-tick pulses once every BIT_DIV cycles. Its divider restarts at 0 on entry to RECORD or PLAY.
- IDLE:
  - A `record` pulse goes to RECORD with the sampled clip. The address and the shift register clear.
  - A `play` pulse goes to PLAY only if that clip's length is nonzero.
  - If `record` and `play` arrive in the same cycle, `record` wins.
- RECORD:
  - On each tick, `audioIn` shifts in MSB-first.
  - After DATA_W ticks, the next cycle drives `ena`=`wea`=1 for the active clip, with `addra`=addr and `dina`=word. The address increments the cycle after.
  - A write to address DEPTH-1 ends recording: length=DEPTH, state returns to IDLE.
  - A `record` pulse stops recording. The partial word is discarded and length = number of words written.
  - `play` is ignored.
- PLAY:
  - Entry cycle issues a read of address 0.
  - `douta` of the active clip loads the output shift register.
  - Each tick advances one bit MSB-first.
  - The read of word n+1 is issued 1 cycle after word n loads and is captured into a hold register, so there is no gap between words.
  - After the last bit of word length-1 has been held BIT_DIV cycles, the state returns to IDLE.
  - A `play` pulse stops playback immediately. `record` is ignored.
- Clip select inputs are ignored mid-operation.
- Lengths are ADDR_W+1 bits wide, one per clip. A new recording overwrites that clip's length.
- All `ena*` and `wea*` are 0 in IDLE. At most one clip's `ena` is high in any cycle.

## Timing
- Reset values: state IDLE, `audioOut`=0, all `ena*`/`wea*`=0, `addra`=0, `dina`=0, both lengths 0, busy flags 0, `activeClip`=0.
- Record: the final sample tick of a word is cycle T. The write strobe is at T+1; `addra` shows addr+1 from T+2.
- Play:
  - The start pulse is at cycle t. The read strobe is at t+1, data is valid at t+2, and the shift register loads at t+2.
  - `audioOut` shows bit 15 of word 0 from t+3. Each bit holds exactly BIT_DIV cycles.
  - After the last bit, `audioOut`=0 and `busyPlay`=0 on the same cycle.
- Stop by pulse: the state is IDLE on the next cycle. No further `ena` is asserted and `audioOut`=0.
- Reset asserted mid-operation clears everything asynchronously. Lengths are lost and any in-flight write is dropped.

## Structure
- Package `audio_pkg` holds the `ADDR_W`/`DATA_W` constants and `typedef enum logic [1:0] {IDLE, RECORD, PLAY} clip_state_t`.
- Sub-module `bit_tick_gen` holds the BIT_DIV divider, with a synchronous restart input and a `tick` output.

## Test plan
All scenarios use DEPTH=4 and BIT_DIV=4.
- Reset-to-idle: pulse `play` on clip 0 with length 0. Required: no `ena0`, `busyPlay` stays 0, `audioOut`=0.
- Full record: record clip 1 with pattern 0xA5C3 repeated. Required: exactly 4 writes with `ena1`/`wea1`, `dina`=0xA5C3, addresses 0..3; return to IDLE; length1=4; `ena0` never high.
- Early stop: record clip 0, stop after 1.5 words. Required: one write of word 0; length0=1; partial word never written.
- Playback: play clip 1 after full record. Required: `audioOut` reproduces 64 bits of 0xA5C3 ×4, each held 4 cycles, first bit at t+3, no inter-word gap; then IDLE.
- Simultaneous and mid-operation events:
  - `record` and `play` in the same cycle: record starts.
  - `play` pulse mid-playback: IDLE on the next cycle, `audioOut`=0.
  - `record` pulse during PLAY: ignored.
- Async reset during RECORD mid-word: outputs cleared immediately; lengths are 0 afterward.
